// File: rtl/logic_equiv_sweeper.sv
// Exhaustive equivalence sweeper: evaluates two selectable bitwise functions over
// every (a,b) operand pair, streaming per-vector results and a mismatch summary.
module logic_equiv_sweeper #(
  parameter int unsigned WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op_a,
  input  logic [2:0]         op_b,
  output logic               busy,
  output logic               done,
  output logic               vec_valid,
  output logic [WIDTH-1:0]   vec_a,
  output logic [WIDTH-1:0]   vec_b,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic               mismatch,
  output logic [2*WIDTH:0]   mism_count,
  output logic               first_valid,
  output logic [WIDTH-1:0]   first_a,
  output logic [WIDTH-1:0]   first_b,
  output logic               equiv
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [2:0]      sel_a_q, sel_b_q;
  logic            launch;
  logic            running;
  logic [WIDTH-1:0] cur_a, cur_b, f_a, f_b;
  logic            cur_mism;

  function automatic logic [WIDTH-1:0] eval_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~(a & b);
      3'd3: r = ~(a | b);
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: r = a & ~b;
      3'd7: r = ~a & b;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    running  = (state_q == S_RUN);
    busy     = running;
    done     = (state_q == S_DONE);
    equiv    = done && (mism_count == '0);
    cur_a    = idx_q[IW-1:WIDTH];
    cur_b    = idx_q[WIDTH-1:0];
    f_a      = eval_op(sel_a_q, cur_a, cur_b);
    f_b      = eval_op(sel_b_q, cur_a, cur_b);
    cur_mism = (f_a != f_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        sel_a_q <= op_a;
        sel_b_q <= op_b;
        idx_q   <= '0;
      end else if (running && idx_q != LAST_IDX) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Result stage: one-cycle-late copy of the vector evaluated during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_valid   <= 1'b0;
      vec_a       <= '0;
      vec_b       <= '0;
      out_a       <= '0;
      out_b       <= '0;
      mismatch    <= 1'b0;
      mism_count  <= '0;
      first_valid <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
    end else begin
      vec_valid <= running;
      mismatch  <= running && cur_mism;
      if (running) begin
        vec_a <= cur_a;
        vec_b <= cur_b;
        out_a <= f_a;
        out_b <= f_b;
        if (cur_mism) begin
          mism_count <= mism_count + (IW+1)'(1);
          if (!first_valid) begin
            first_valid <= 1'b1;
            first_a     <= cur_a;
            first_b     <= cur_b;
          end
        end
      end else if (launch) begin
        mism_count  <= '0;
        first_valid <= 1'b0;
        first_a     <= '0;
        first_b     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_logic_equiv_sweeper.sv
// Bench for logic_equiv_sweeper: WIDTH=1 and WIDTH=2 instances checked against a
// truth-table reference model with directed and random function pairs.
module tb_logic_equiv_sweeper;

  logic clk = 1'b0;
  logic rst_n, start, sel_w1;
  logic [2:0] op_a, op_b;
  logic start1, start2;
  int checks = 0;
  int errors = 0;

  logic busy1, done1, vv1, mis1, fv1, eq1;
  logic [0:0] va1, vb1, oa1, ob1, fa1, fb1;
  logic [2:0] mc1;
  logic busy2, done2, vv2, mis2, fv2, eq2;
  logic [1:0] va2, vb2, oa2, ob2, fa2, fb2;
  logic [4:0] mc2;

  logic o_busy, o_done, o_vv, o_mis, o_fv, o_eq;
  logic [31:0] o_va, o_vb, o_oa, o_ob, o_mc, o_fa, o_fb;

  // Truth tables indexed by {a_bit, b_bit}.
  logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                         4'b0110, 4'b1001, 4'b0100, 4'b0010};

  always #5 clk = ~clk;

  assign start1 = start & sel_w1;
  assign start2 = start & ~sel_w1;

  logic_equiv_sweeper #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a), .op_b(op_b),
    .busy(busy1), .done(done1), .vec_valid(vv1), .vec_a(va1), .vec_b(vb1),
    .out_a(oa1), .out_b(ob1), .mismatch(mis1), .mism_count(mc1),
    .first_valid(fv1), .first_a(fa1), .first_b(fb1), .equiv(eq1));

  logic_equiv_sweeper #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op_a(op_a), .op_b(op_b),
    .busy(busy2), .done(done2), .vec_valid(vv2), .vec_a(va2), .vec_b(vb2),
    .out_a(oa2), .out_b(ob2), .mismatch(mis2), .mism_count(mc2),
    .first_valid(fv2), .first_a(fa2), .first_b(fb2), .equiv(eq2));

  always_comb begin
    if (sel_w1) begin
      o_busy = busy1; o_done = done1; o_vv = vv1; o_mis = mis1; o_fv = fv1; o_eq = eq1;
      o_va = 32'(va1); o_vb = 32'(vb1); o_oa = 32'(oa1); o_ob = 32'(ob1);
      o_mc = 32'(mc1); o_fa = 32'(fa1); o_fb = 32'(fb1);
    end else begin
      o_busy = busy2; o_done = done2; o_vv = vv2; o_mis = mis2; o_fv = fv2; o_eq = eq2;
      o_va = 32'(va2); o_vb = 32'(vb2); o_oa = 32'(oa2); o_ob = 32'(ob2);
      o_mc = 32'(mc2); o_fa = 32'(fa2); o_fb = 32'(fb2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_f(input int op, input int a, input int b, input int w);
    int r;
    logic [3:0] t;
    r = 0;
    t = tt[op];
    for (int k = 0; k < w; k++) begin
      if (t[2 * ((a >> k) & 1) + ((b >> k) & 1)]) r |= (1 << k);
    end
    return r;
  endfunction

  task automatic run_sweep(input bit w1, input logic [2:0] oa, input logic [2:0] ob,
                           input bit disturb);
    int n, w, a, b, ra, rb, cnt, fa_e, fb_e;
    bit fv;
    sel_w1 = w1;
    w = w1 ? 1 : 2;
    n = 1 << (2 * w);
    @(negedge clk);
    op_a = oa; op_b = ob; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("entry_busy", 32'(o_busy), 1);
    check("entry_valid", 32'(o_vv), 0);
    check("entry_count_clear", o_mc, 0);
    check("entry_first_clear", 32'(o_fv), 0);
    if (disturb) begin
      start = 1'b1;
      op_a = oa ^ 3'b011;
    end
    cnt = 0; fv = 0; fa_e = 0; fb_e = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (disturb && i == 0) start = 1'b0;
      a = i >> w;
      b = i & ((1 << w) - 1);
      ra = ref_f(int'(oa), a, b, w);
      rb = ref_f(int'(ob), a, b, w);
      if (ra != rb) begin
        cnt++;
        if (!fv) begin fv = 1; fa_e = a; fb_e = b; end
      end
      check("vec_valid", 32'(o_vv), 1);
      check("vec_a", o_va, a);
      check("vec_b", o_vb, b);
      check("out_a", o_oa, ra);
      check("out_b", o_ob, rb);
      check("mismatch", 32'(o_mis), (ra != rb) ? 1 : 0);
      check("mism_count", o_mc, cnt);
      check("first_valid", 32'(o_fv), fv);
      if (fv) begin
        check("first_a", o_fa, fa_e);
        check("first_b", o_fb, fb_e);
      end
      check("busy", 32'(o_busy), (i != n - 1) ? 1 : 0);
      check("done", 32'(o_done), (i == n - 1) ? 1 : 0);
      check("equiv_run", 32'(o_eq), (i == n - 1 && cnt == 0) ? 1 : 0);
    end
    @(negedge clk);
    check("done_hold", 32'(o_done), 1);
    check("busy_after", 32'(o_busy), 0);
    check("valid_after", 32'(o_vv), 0);
    check("count_hold", o_mc, cnt);
    check("equiv_hold", 32'(o_eq), (cnt == 0) ? 1 : 0);
    check("first_hold", 32'(o_fv), fv);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 40 && o_done !== 1'b1; k++) @(negedge clk);
    check(tag, 32'(o_done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; sel_w1 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_w1", {o_busy, o_done, o_vv, o_fv, o_eq, o_mc[27:0]}, 0);
    sel_w1 = 1'b0;
    #1;
    check("rst_w2", {o_busy, o_done, o_vv, o_fv, o_eq, o_mc[27:0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(1'b1, 3'd3, 3'd7, 1'b0);
    check("s1_count", o_mc, 2);
    check("s1_first_a", o_fa, 0);
    check("s1_first_b", o_fb, 0);

    run_sweep(1'b1, 3'd2, 3'd2, 1'b0);
    check("s2_equiv", 32'(o_eq), 1);
    check("s2_first_valid", 32'(o_fv), 0);

    run_sweep(1'b0, 3'd0, 3'd1, 1'b0);
    check("s3_count", o_mc, 12);
    check("s3_first_a", o_fa, 0);
    check("s3_first_b", o_fb, 1);

    run_sweep(1'b0, 3'd0, 3'd1, 1'b1);
    check("s4_count", o_mc, 12);
    check("s4_first_b", o_fb, 1);

    run_sweep(1'b0, 3'd4, 3'd5, 1'b0);
    check("s6_count", o_mc, 16);
    check("s6_first_a", o_fa, 0);
    check("s6_first_b", o_fb, 0);

    // Start held high across a sweep: accepted again in the first DONE cycle.
    start = 1'b1;
    @(negedge clk);
    check("held_busy", 32'(o_busy), 1);
    check("held_cleared", o_mc, 0);
    wait_done("held_done");
    check("held_count", o_mc, 16);
    @(negedge clk);
    check("held_reaccept", 32'(o_busy), 1);
    start = 1'b0;
    wait_done("held_done2");

    // Reset in the middle of a WIDTH=2 sweep.
    sel_w1 = 1'b0;
    @(negedge clk);
    op_a = 3'd0; op_b = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_vec", o_va * 4 + o_vb, 4);
    rst_n = 1'b0;
    #1;
    check("reset_mid_run", 32'({busy2, done2, vv2, va2, vb2, oa2, ob2, mis2, mc2,
                                fv2, fa2, fb2, eq2}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b0, 3'd0, 3'd1, 1'b0);
    check("s5_restart_count", o_mc, 12);

    for (int r = 0; r < 6; r++) begin
      run_sweep(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
